// File: rtl/seq_dump_pkg.sv
// seq_dump_pkg: ASCII constants, FSM encoding and hex helper shared by the dump logic
package seq_dump_pkg;
   localparam int DEF_CLKS_PER_BIT = 104;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   typedef enum logic [3:0] {
      IDLE, FETCH, WAIT_DATA, SEND, WAIT_TX, SEND_CR, WAIT_CR, SEND_LF, WAIT_LF
   } state_t;
   function automatic logic [7:0] hex_char(input logic [3:0] v);
      return (v < 4'd10) ? ASCII_0 + {4'd0, v} : ASCII_A + {4'd0, v} - 8'd10;
   endfunction
endpackage

// File: rtl/seq_dump_uart_tx.sv
// uart_tx: 8N1 serialiser; tx_done marks the final cycle of the stop bit
module uart_tx import seq_dump_pkg::*; #(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_btn,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   output logic       tx_busy,
   output logic       tx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
   logic [CW-1:0] cnt;
   logic [3:0]    idx;
   logic [7:0]    shreg;
   // idx counts bits already started: 0 = start bit, 1..8 = data, 9 = stop
   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         tx      <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
      end else begin
         tx_done <= tx_busy && idx == 4'd9 && cnt == PRE;
         if (!tx_busy) begin
            if (tx_start) begin
               tx_busy <= 1'b1;
               tx      <= 1'b0;
               shreg   <= tx_data;
               cnt     <= '0;
               idx     <= '0;
            end
         end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
            if (idx == 4'd9) begin
               tx_busy <= 1'b0;
               tx      <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
               tx  <= (idx == 4'd8) ? 1'b1 : shreg[idx[2:0]];
            end
         end
      end
   end
endmodule

// File: rtl/seq_dump.sv
// seq_dump: walks the step memory and sends each step as a hex character, then CR LF
module seq_dump import seq_dump_pkg::*; #(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int NUM_STEPS    = 8,
   parameter int ADDR_WIDTH   = 3,
   parameter int DATA_WIDTH   = 2
) (
   input  logic                  clk,
   input  logic                  rst_btn,
   input  logic                  dump_req,
   input  logic [DATA_WIDTH-1:0] mem_r_data,
   output logic                  mem_r_en,
   output logic [ADDR_WIDTH-1:0] mem_r_addr,
   output logic                  busy,
   output logic                  tx
);
   localparam logic [ADDR_WIDTH-1:0] LAST_STEP = ADDR_WIDTH'(NUM_STEPS - 1);
   state_t                state;
   logic [ADDR_WIDTH-1:0] step;
   logic                  req_q;
   logic                  tx_start;
   logic [7:0]            tx_data;
   logic                  tx_done;
   logic                  uart_busy;
   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk(clk), .rst_btn(rst_btn), .tx_start(tx_start), .tx_data(tx_data),
      .tx_done(tx_done), .tx_busy(uart_busy), .tx(tx)
   );
   // Requests are only latched while idle, so pulses during a dump are dropped
   always_ff @(posedge clk) begin
      if (!rst_btn) begin
         state      <= IDLE;
         busy       <= 1'b0;
         mem_r_en   <= 1'b0;
         mem_r_addr <= '0;
         step       <= '0;
         req_q      <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
      end else begin
         req_q    <= dump_req && state == IDLE && !req_q;
         tx_start <= 1'b0;
         mem_r_en <= 1'b0;
         case (state)
            IDLE: if (req_q && !uart_busy) begin
               state      <= FETCH;
               busy       <= 1'b1;
               step       <= '0;
               mem_r_en   <= 1'b1;
               mem_r_addr <= '0;
            end
            FETCH: state <= WAIT_DATA;
            WAIT_DATA: begin
               tx_data  <= hex_char(4'(mem_r_data));
               tx_start <= 1'b1;
               state    <= SEND;
            end
            SEND: state <= WAIT_TX;
            WAIT_TX: if (tx_done) begin
               if (step == LAST_STEP) begin
                  tx_data  <= ASCII_CR;
                  tx_start <= 1'b1;
                  state    <= SEND_CR;
               end else begin
                  step       <= step + 1'b1;
                  mem_r_addr <= step + 1'b1;
                  mem_r_en   <= 1'b1;
                  state      <= FETCH;
               end
            end
            SEND_CR: state <= WAIT_CR;
            WAIT_CR: if (tx_done) begin
               tx_data  <= ASCII_LF;
               tx_start <= 1'b1;
               state    <= SEND_LF;
            end
            SEND_LF: state <= WAIT_LF;
            WAIT_LF: if (tx_done) begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_dump.sv
// tb_seq_dump: directed dumps decoded by a bench UART receiver against hand-computed strings
module tb_seq_dump;
   localparam int CPB = 4;
   logic       clk = 1'b0;
   logic       rst_btn, dump_req_a, dump_req_b;
   logic [1:0] rdata_a;
   logic [3:0] rdata_b;
   logic       mem_r_en_a, mem_r_en_b, busy_a, busy_b, tx_a, tx_b;
   logic [2:0] mem_r_addr_a;
   logic [1:0] mem_r_addr_b;
   logic [1:0] mem_a [8];
   logic [3:0] mem_b [4];
   int         cyc = 0;
   int         checks = 0;
   int         errs = 0;
   int         bitbad, req_edge, fall_cyc, viol;
   logic [7:0] rxq [10];
   int         tsq [10];
   logic [2:0] alog [$];
   int         elog [$];
   logic       busy_prev = 1'b0;

   seq_dump #(.CLKS_PER_BIT(CPB), .NUM_STEPS(8), .ADDR_WIDTH(3), .DATA_WIDTH(2)) dut_a (
      .clk(clk), .rst_btn(rst_btn), .dump_req(dump_req_a), .mem_r_data(rdata_a),
      .mem_r_en(mem_r_en_a), .mem_r_addr(mem_r_addr_a), .busy(busy_a), .tx(tx_a)
   );
   seq_dump #(.CLKS_PER_BIT(CPB), .NUM_STEPS(4), .ADDR_WIDTH(2), .DATA_WIDTH(4)) dut_b (
      .clk(clk), .rst_btn(rst_btn), .dump_req(dump_req_b), .mem_r_data(rdata_b),
      .mem_r_en(mem_r_en_b), .mem_r_addr(mem_r_addr_b), .busy(busy_b), .tx(tx_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mem_r_en_a) rdata_a <= mem_a[mem_r_addr_a];
   always @(posedge clk) if (mem_r_en_b) rdata_b <= mem_b[mem_r_addr_b];
   always @(negedge clk) begin
      if (mem_r_en_a) begin
         alog.push_back(mem_r_addr_a);
         elog.push_back(cyc);
      end
      if (busy_prev && !busy_a) fall_cyc = cyc;
      busy_prev = busy_a;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic txs(input bit sel);
      return sel ? tx_b : tx_a;
   endfunction

   task automatic rx_byte(input bit sel, output logic [7:0] b, output int ts);
      logic [9:0] f;
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (txs(sel) !== 1'b0 && n < 3000);
      ts = cyc;
      f = '0;
      if (txs(sel) !== 1'b0) chk("rx_timeout", 32'(n), 0);
      else begin
         for (int i = 0; i < 10; i++) begin
            f[i] = txs(sel);
            for (int j = 1; j < CPB; j++) begin
               @(negedge clk);
               if (txs(sel) !== f[i]) bitbad++;
            end
            if (i < 9) @(negedge clk);
         end
         if (f[0] !== 1'b0 || f[9] !== 1'b1) bitbad++;
      end
      b = f[8:1];
   endtask

   task automatic rx_n(input bit sel, input int n);
      bitbad = 0;
      for (int i = 0; i < n; i++) rx_byte(sel, rxq[i], tsq[i]);
   endtask

   task automatic chk_str(input string pfx, input string s);
      for (int i = 0; i < s.len(); i++) chk($sformatf("%s_byte%0d", pfx, i), 32'(rxq[i]), 32'(s[i]));
   endtask

   task automatic pulse(input bit sel);
      @(negedge clk);
      if (sel) dump_req_b = 1'b1; else dump_req_a = 1'b1;
      req_edge = cyc + 1;
      @(negedge clk);
      dump_req_a = 1'b0;
      dump_req_b = 1'b0;
   endtask

   task automatic load_pattern();
      mem_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
   endtask

   initial begin
      rst_btn = 1'b0;
      dump_req_a = 1'b0;
      dump_req_b = 1'b0;
      load_pattern();
      mem_b = '{4'd9, 4'd10, 4'd15, 4'd0};
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx_a), 1);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_en", 32'(mem_r_en_a), 0);
      chk("rst_addr", 32'(mem_r_addr_a), 0);
      rst_btn = 1'b1;
      viol = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || mem_r_en_a !== 1'b0) viol++;
      end
      chk("idle_viol", 32'(viol), 0);

      alog.delete();
      elog.delete();
      pulse(0);
      rx_n(0, 10);
      chk_str("full", "01233210\015\012");
      chk("full_addr_cnt", 32'(alog.size()), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("full_addr%0d", i), 32'(alog[i]), 32'(i));
      chk("full_en_lat", 32'(elog[0] - req_edge), 1);
      repeat (2) @(negedge clk);
      chk("full_busy_fall", 32'(fall_cyc - tsq[9]), 40);
      chk("full_bits", 32'(bitbad), 0);

      foreach (mem_a[i]) mem_a[i] = 2'd3;
      pulse(0);
      rx_n(0, 10);
      chk_str("tim", "33333333\015\012");
      chk("tim_start_lat", 32'(tsq[0] - req_edge), 4);
      for (int i = 0; i < 7; i++) chk($sformatf("tim_step_gap%0d", i), 32'(tsq[i+1] - tsq[i]), 10 * CPB + 3);
      chk("tim_cr_gap", 32'(tsq[8] - tsq[7]), 10 * CPB + 1);
      chk("tim_lf_gap", 32'(tsq[9] - tsq[8]), 10 * CPB + 1);
      chk("tim_bits", 32'(bitbad), 0);

      load_pattern();
      pulse(0);
      fork
         rx_n(0, 10);
         begin
            repeat (100) @(negedge clk);
            dump_req_a = 1'b1;
            @(negedge clk);
            dump_req_a = 1'b0;
         end
      join
      chk_str("ign", "01233210\015\012");
      @(negedge clk);
      chk("ign_busy_low", 32'(busy_a), 0);
      dump_req_a = 1'b1;
      req_edge = cyc + 1;
      @(negedge clk);
      dump_req_a = 1'b0;
      rx_n(0, 10);
      chk_str("again", "01233210\015\012");
      chk("again_start_lat", 32'(tsq[0] - req_edge), 4);

      pulse(0);
      repeat (55) @(negedge clk);
      chk("mid_pre_tx", 32'(tx_a), 0);
      rst_btn = 1'b0;
      @(negedge clk);
      chk("mid_rst_tx", 32'(tx_a), 1);
      chk("mid_rst_busy", 32'(busy_a), 0);
      rst_btn = 1'b1;
      repeat (3) @(negedge clk);
      alog.delete();
      pulse(0);
      rx_n(0, 10);
      chk_str("restart", "01233210\015\012");
      chk("restart_addr_cnt", 32'(alog.size()), 8);
      chk("restart_addr0", 32'(alog[0]), 0);

      pulse(1);
      rx_n(1, 6);
      chk_str("hex", "9AF0\015\012");
      chk("hex_bits", 32'(bitbad), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
